input_cond: RTL and testbench

INPUT_COND -- requirements
Module: input_cond

---
 rtl/input_cond_if.sv | 27 ++
 rtl/input_cond.sv | 211 +++++++++++++++++++++
 tb/tb_input_cond.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/input_cond_if.sv
// Pad-side bundle for input_cond: active-low sensor/button levels in, conditioned pulses and levels out.
interface input_cond_if;
    logic nFork;
    logic nCrank;
    logic nMode;
    logic nTrip;
    logic ForkPulse;
    logic CrankPulse;
    logic ModePress;
    logic TripPress;
    logic ModeLong;
    logic TripLong;
    logic ModeHeld;
    logic TripHeld;

    modport master (
        output nFork, nCrank, nMode, nTrip,
        input  ForkPulse, CrankPulse, ModePress, TripPress,
        input  ModeLong, TripLong, ModeHeld, TripHeld
    );

    modport slave (
        input  nFork, nCrank, nMode, nTrip,
        output ForkPulse, CrankPulse, ModePress, TripPress,
        output ModeLong, TripLong, ModeHeld, TripHeld
    );
endinterface

// File: rtl/input_cond.sv
// Input conditioning: 2-flop synchronisers, wheel/crank edge pulses with lockout, mode/trip button FSMs.
// Define INPUT_COND_DEBOUNCE_EN to enable press/release debouncing in the button FSMs.
module input_cond #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int LONG_CYCLES     = 65536,
    parameter int MIN_GAP         = 64
) (
    input  logic        Clock,
    input  logic        Reset,
    input_cond_if.slave pads
);

    localparam int BMAX = (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES : LONG_CYCLES;
    localparam int BW   = $clog2(BMAX + 1);
    localparam int GW   = $clog2(MIN_GAP + 1);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_PRESS_DB = 2'd1;
    localparam logic [1:0] ST_PRESSED  = 2'd2;
    localparam logic [1:0] ST_REL_DB   = 2'd3;

    // Channel order: 0 fork, 1 crank, 2 mode, 3 trip.
    logic [3:0] pad;
    logic [3:0] sync1_q;
    logic [3:0] sync2_q;
    logic [3:0] prev_q;
    logic [1:0] settle_q;
    logic [3:0] fall;

    logic [1:0] spulse;
    logic [1:0] bpress;
    logic [1:0] blong;
    logic [1:0] bheld;

    assign pad  = {pads.nTrip, pads.nMode, pads.nCrank, pads.nFork};
    assign fall = prev_q & ~sync2_q;

    // prev_q stays 0 until the synchronisers hold real pad samples, so an input
    // low across reset release needs a genuine high before any fall is seen.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync1_q  <= '1;
            sync2_q  <= '1;
            prev_q   <= '0;
            settle_q <= '0;
        end else begin
            sync1_q  <= pad;
            sync2_q  <= sync1_q;
            settle_q <= {settle_q[0], 1'b1};
            if (settle_q[1]) begin
                prev_q <= sync2_q;
            end
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_sensor
        logic [GW-1:0] gap_q;
        logic [GW-1:0] gap_d;
        logic          pulse_q;
        logic          pulse_d;

        always_comb begin
            gap_d   = gap_q;
            pulse_d = 1'b0;
            if (fall[g] && (gap_q == '0)) begin
                pulse_d = 1'b1;
                gap_d   = GW'(MIN_GAP);
            end else if (gap_q != '0) begin
                gap_d = gap_q - 1'b1;
            end
        end

        always_ff @(posedge Clock) begin
            if (Reset) begin
                gap_q   <= '0;
                pulse_q <= 1'b0;
            end else begin
                gap_q   <= gap_d;
                pulse_q <= pulse_d;
            end
        end

        assign spulse[g] = pulse_q;
    end

    for (genvar g = 0; g < 2; g++) begin : g_button
        logic          lvl;
        logic          bfall;
        logic [1:0]    st_q;
        logic [1:0]    st_d;
        logic [BW-1:0] hold_q;
        logic [BW-1:0] hold_d;
        logic          press_q;
        logic          press_d;
        logic          long_q;
        logic          long_d;
        logic          held_q;
        logic          held_d;
`ifdef INPUT_COND_DEBOUNCE_EN
        logic [BW-1:0] db_q;
        logic [BW-1:0] db_d;
`endif

        assign lvl   = sync2_q[2+g];
        assign bfall = fall[2+g];

        always_comb begin
            st_d    = st_q;
            hold_d  = hold_q;
            press_d = 1'b0;
            long_d  = 1'b0;
`ifdef INPUT_COND_DEBOUNCE_EN
            db_d    = db_q;
`endif
            case (st_q)
                ST_IDLE: begin
                    if (bfall) begin
`ifdef INPUT_COND_DEBOUNCE_EN
                        st_d = ST_PRESS_DB;
                        db_d = '0;
`else
                        st_d    = ST_PRESSED;
                        press_d = 1'b1;
                        hold_d  = '0;
`endif
                    end
                end
                ST_PRESSED: begin
                    if (lvl) begin
`ifdef INPUT_COND_DEBOUNCE_EN
                        st_d = ST_REL_DB;
                        db_d = '0;
`else
                        st_d = ST_IDLE;
`endif
                    end else if (hold_q != BW'(LONG_CYCLES)) begin
                        hold_d = hold_q + 1'b1;
                        long_d = (hold_q == BW'(LONG_CYCLES - 1));
                    end
                end
`ifdef INPUT_COND_DEBOUNCE_EN
                ST_PRESS_DB: begin
                    if (lvl) begin
                        st_d = ST_IDLE;
                    end else if (db_q == BW'(DEBOUNCE_CYCLES - 1)) begin
                        st_d    = ST_PRESSED;
                        press_d = 1'b1;
                        hold_d  = '0;
                    end else begin
                        db_d = db_q + 1'b1;
                    end
                end
                // A bounce back low resumes the press with the hold count intact.
                ST_REL_DB: begin
                    if (!lvl) begin
                        st_d = ST_PRESSED;
                    end else if (db_q == BW'(DEBOUNCE_CYCLES - 1)) begin
                        st_d = ST_IDLE;
                    end else begin
                        db_d = db_q + 1'b1;
                    end
                end
`else
                ST_PRESS_DB, ST_REL_DB: begin
                    st_d = ST_IDLE;
                end
`endif
                default: begin
                    st_d = ST_IDLE;
                end
            endcase
            held_d = (st_d == ST_PRESSED);
        end

        always_ff @(posedge Clock) begin
            if (Reset) begin
                st_q    <= ST_IDLE;
                hold_q  <= '0;
                press_q <= 1'b0;
                long_q  <= 1'b0;
                held_q  <= 1'b0;
`ifdef INPUT_COND_DEBOUNCE_EN
                db_q    <= '0;
`endif
            end else begin
                st_q    <= st_d;
                hold_q  <= hold_d;
                press_q <= press_d;
                long_q  <= long_d;
                held_q  <= held_d;
`ifdef INPUT_COND_DEBOUNCE_EN
                db_q    <= db_d;
`endif
            end
        end

        assign bpress[g] = press_q;
        assign blong[g]  = long_q;
        assign bheld[g]  = held_q;
    end

    assign pads.ForkPulse  = spulse[0];
    assign pads.CrankPulse = spulse[1];
    assign pads.ModePress  = bpress[0];
    assign pads.TripPress  = bpress[1];
    assign pads.ModeLong   = blong[0];
    assign pads.TripLong   = blong[1];
    assign pads.ModeHeld   = bheld[0];
    assign pads.TripHeld   = bheld[1];

endmodule

// File: tb/tb_input_cond.sv
// Scoreboard bench for input_cond: expected output events are queued when pads are driven
// and compared against all eight outputs every cycle.
module tb_input_cond;

    localparam int DEB  = 16;
    localparam int LONG = 100;
    localparam int GAP  = 64;
`ifdef INPUT_COND_DEBOUNCE_EN
    localparam int PDLY = 3 + DEB;
`else
    localparam int PDLY = 3;
`endif

    // Output bit order: 0 Fork,1 Crank,2 ModePress,3 TripPress,4 ModeLong,5 TripLong,6 ModeHeld,7 TripHeld.
    localparam int K_PULSE = 0;
    localparam int K_SET   = 1;
    localparam int K_CLR   = 2;

    typedef struct {
        int cyc;
        int idx;
        int kind;
    } ev_t;

    logic Clock = 1'b0;
    logic Reset;
    input_cond_if pads();

    input_cond #(
        .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES    (LONG),
        .MIN_GAP        (GAP)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .pads (pads)
    );

    always #5 Clock = ~Clock;

    ev_t        exp_q[$];
    int         cyc;
    int         n_checks;
    int         n_errors;
    logic [1:0] exp_held;

    task automatic check_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] observed();
        return {pads.TripHeld, pads.ModeHeld, pads.TripLong, pads.ModeLong,
                pads.TripPress, pads.ModePress, pads.CrankPulse, pads.ForkPulse};
    endfunction

    task automatic expect_ev(input int at, input int idx, input int kind);
        ev_t e;
        e.cyc  = at;
        e.idx  = idx;
        e.kind = kind;
        exp_q.push_back(e);
    endtask

    task automatic step();
        logic [7:0] e;
        int k;
        @(posedge Clock);
        #1;
        cyc++;
        e = '0;
        k = 0;
        while (k < exp_q.size()) begin
            if (exp_q[k].cyc == cyc) begin
                case (exp_q[k].kind)
                    K_PULSE: e[exp_q[k].idx] = 1'b1;
                    K_SET:   exp_held[exp_q[k].idx - 6] = 1'b1;
                    default: exp_held[exp_q[k].idx - 6] = 1'b0;
                endcase
                exp_q.delete(k);
            end else begin
                k++;
            end
        end
        e[7:6] = exp_held;
        check_eq("outputs", observed(), e);
    endtask

    task automatic wait_n(input int n);
        repeat (n) step();
    endtask

    initial begin
        int c;
        int g;
        int r;
        cyc      = 0;
        n_checks = 0;
        n_errors = 0;
        exp_held = '0;
        Reset       = 1'b1;
        pads.nFork  = 1'b1;
        pads.nCrank = 1'b1;
        pads.nMode  = 1'b1;
        pads.nTrip  = 1'b1;
        wait_n(3);
        Reset = 1'b0;
        wait_n(6);

        // Single fork fall: one pulse on the 3rd edge.
        c = cyc;
        expect_ev(c + 3, 0, K_PULSE);
        pads.nFork = 1'b0;
        wait_n(10);
        pads.nFork = 1'b1;
        wait_n(80);

        // Five falls 20 cycles apart: lockout drops the middle three.
        for (int k = 0; k < 5; k++) begin
            c = cyc;
            if (k == 0 || k == 4) expect_ev(c + 3, 0, K_PULSE);
            pads.nFork = 1'b0;
            wait_n(10);
            pads.nFork = 1'b1;
            wait_n(10);
        end
        wait_n(70);

        // Mode: 10 low, 3 high, 40 low.
        c = cyc;
`ifdef INPUT_COND_DEBOUNCE_EN
        expect_ev(c + 13 + PDLY, 2, K_PULSE);
        expect_ev(c + 13 + PDLY, 6, K_SET);
`else
        expect_ev(c + 3, 2, K_PULSE);
        expect_ev(c + 3, 6, K_SET);
        expect_ev(c + 13, 6, K_CLR);
        expect_ev(c + 16, 2, K_PULSE);
        expect_ev(c + 16, 6, K_SET);
`endif
        expect_ev(c + 56, 6, K_CLR);
        pads.nMode = 1'b0;
        wait_n(10);
        pads.nMode = 1'b1;
        wait_n(3);
        pads.nMode = 1'b0;
        wait_n(40);
        pads.nMode = 1'b1;
        wait_n(40);

        // Trip held 300 cycles: one press, one long 100 cycles later.
        c = cyc;
        expect_ev(c + PDLY, 3, K_PULSE);
        expect_ev(c + PDLY, 7, K_SET);
        expect_ev(c + PDLY + LONG, 5, K_PULSE);
        expect_ev(c + 303, 7, K_CLR);
        pads.nTrip = 1'b0;
        wait_n(300);
        pads.nTrip = 1'b1;
        wait_n(40);

        // Trip with a 5-cycle high glitch mid-hold.
        c = cyc;
        expect_ev(c + PDLY, 3, K_PULSE);
        expect_ev(c + PDLY, 7, K_SET);
        pads.nTrip = 1'b0;
        wait_n(PDLY + 20);
        g = cyc;
        expect_ev(g + 3, 7, K_CLR);
        expect_ev(g + 8, 7, K_SET);
`ifndef INPUT_COND_DEBOUNCE_EN
        expect_ev(g + 8, 3, K_PULSE);
`endif
        expect_ev(g + 38, 7, K_CLR);
        pads.nTrip = 1'b1;
        wait_n(5);
        pads.nTrip = 1'b0;
        wait_n(30);
        pads.nTrip = 1'b1;
        wait_n(40);

        // Reset while crank held low and in lockout.
        c = cyc;
        expect_ev(c + 3, 1, K_PULSE);
        pads.nCrank = 1'b0;
        wait_n(20);
        Reset = 1'b1;
        wait_n(2);
        Reset = 1'b0;
        wait_n(30);
        pads.nCrank = 1'b1;
        wait_n(5);
        c = cyc;
        expect_ev(c + 3, 1, K_PULSE);
        pads.nCrank = 1'b0;
        wait_n(10);
        pads.nCrank = 1'b1;
        wait_n(10);

        // Reset mid-press on mode.
        c = cyc;
        expect_ev(c + PDLY, 2, K_PULSE);
        expect_ev(c + PDLY, 6, K_SET);
        pads.nMode = 1'b0;
        wait_n(PDLY + 10);
        expect_ev(cyc + 1, 6, K_CLR);
        Reset = 1'b1;
        wait_n(2);
        Reset = 1'b0;
        wait_n(30);
        pads.nMode = 1'b1;
        wait_n(5);
        c = cyc;
        expect_ev(c + PDLY, 2, K_PULSE);
        expect_ev(c + PDLY, 6, K_SET);
        pads.nMode = 1'b0;
        wait_n(PDLY + 5);
        r = cyc;
        expect_ev(r + 3, 6, K_CLR);
        pads.nMode = 1'b1;
        wait_n(70);

        // All four fall together.
        c = cyc;
        expect_ev(c + 3, 0, K_PULSE);
        expect_ev(c + 3, 1, K_PULSE);
        expect_ev(c + PDLY, 2, K_PULSE);
        expect_ev(c + PDLY, 3, K_PULSE);
        expect_ev(c + PDLY, 6, K_SET);
        expect_ev(c + PDLY, 7, K_SET);
        pads.nFork  = 1'b0;
        pads.nCrank = 1'b0;
        pads.nMode  = 1'b0;
        pads.nTrip  = 1'b0;
        wait_n(PDLY + 5);
        r = cyc;
        expect_ev(r + 3, 6, K_CLR);
        expect_ev(r + 3, 7, K_CLR);
        pads.nFork  = 1'b1;
        pads.nCrank = 1'b1;
        pads.nMode  = 1'b1;
        pads.nTrip  = 1'b1;
        wait_n(40);

        check_eq("pending_events", 8'(exp_q.size()), 8'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
